mem_lsu_ctrl: RTL and testbench
===============================

Name: mem_lsu_ctrl

Overview:
MEM-stage load/store unit. It consumes the registered EX→MEM bundle (pc, inst, ex_result as address or ALU result, rw_en, rw_addr, lsu_data, lsu_op) and acts as the initiator on the data bus: it issues requests, waits for grant and response, and aligns or extends load data. It produces the registered MEM→WB bundle and holds the upstream pipeline (in_ready low) while a memory access is outstanding.

Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width (fixed at 32 for byte-lane logic)
- TIMEOUT_CYCLES, 255, response timeout limit; used only with LSU_TIMEOUT_EN

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- in_valid  in  1  EX→MEM bundle valid
- in_ready  out  1  MEM accepts the bundle this cycle
- in_pc  in  32  instruction pc
- in_inst  in  32  instruction word
- in_ex_result  in  32  ALU result, or effective address for memory ops
- in_rw_en  in  1  register writeback enable
- in_rw_addr  in  5  destination register
- in_lsu_data  in  32  store data (rd value)
- in_lsu_op  in  4  0=NONE 1=LD_B 2=LD_H 3=LD_W 4=LD_BU 5=LD_HU 6=ST_B 7=ST_H 8=ST_W; 9–15 treated as NONE
- dbus_req  out  1  request valid
- dbus_we  out  1  1 = store
- dbus_addr  out  32  word-aligned address ({addr[31:2],2'b00})
- dbus_wstrb  out  4  byte strobes
- dbus_wdata  out  32  store data replicated to the target lanes
- dbus_gnt  in  1  request accepted
- dbus_rvalid  in  1  response valid (for loads and stores)
- dbus_rdata  in  32  load data word
- out_valid  out  1  MEM→WB bundle valid (1-cycle pulse per instruction)
- out_pc / out_inst  out  32  passthrough
- out_rw_en  out  1  writeback enable
- out_rw_addr  out  5  destination register
- out_wdata  out  32  writeback data
- out_ale  out  1  address-misalignment exception flag
- out_bus_err  out  1  bus timeout flag; constant 0 without LSU_TIMEOUT_EN

Behaviour:
- Reset: all out_* = 0, dbus_req = 0, dbus_we = 0, dbus_addr/wstrb/wdata = 0, FSM = IDLE, in_ready = 0 during reset.
- FSM states are IDLE, REQ and WAIT. in_ready = (state==IDLE).
- IDLE, in_valid, op NONE: next cycle out_valid=1, out_wdata=in_ex_result, rw fields passed through. State stays IDLE, so throughput is 1 instruction per cycle.
- IDLE, in_valid, misaligned (halfword with addr[0]=1, or word with addr[1:0]≠0): no bus request. Next cycle out_valid=1, out_ale=1, out_rw_en=0.
- IDLE, in_valid, aligned memory op:
  - Latch the bundle, op and addr[1:0].
  - Next cycle dbus_req=1 with addr, we and wstrb set. ST_B strobe = 1<<addr[1:0]. ST_H strobe = 4'b0011<<addr[1:0]. ST_W strobe = 4'hF. Loads drive wstrb=0.
  - wdata replicates the byte or halfword to all lanes.
  - State goes to REQ.
- REQ: dbus_req and its fields are held stable until dbus_gnt.
  - On gnt, req drops next cycle and state goes to WAIT.
  - If gnt and rvalid arrive in the same cycle, the access completes directly (as in WAIT).
- WAIT: on dbus_rvalid, next cycle out_valid=1 and state returns to IDLE.
  - Loads select the byte or halfword at addr[1:0] from rdata. LD_B/LD_H sign-extend; LD_BU/LD_HU zero-extend; LD_W takes the full word.
  - Stores complete with out_rw_en=0.
- dbus_rvalid outside REQ/WAIT is ignored.
- out_valid is low in every cycle without a completion. out_* hold their last values between completions.
- Reset mid-access: return to IDLE, drop dbus_req immediately. A stale rvalid arriving after reset is ignored.

Optional Feature:
- Macro: LSU_TIMEOUT_EN.
- With the macro: an 8+ bit counter clears on entering WAIT and increments each WAIT cycle without rvalid. When it reaches TIMEOUT_CYCLES, the instruction completes with out_valid=1, out_bus_err=1 and out_rw_en=0, and state returns to IDLE.
- Without the macro: no counter; WAIT is held indefinitely and out_bus_err is tied to 0.

Test Plan:
- Non-memory op, in_ex_result=0x1234, rw_addr=3, three back-to-back cycles → three consecutive out_valid pulses, out_wdata=0x1234, in_ready constantly 1.
- LD_B at addr 0x1003, gnt after 2 cycles, rdata=0x80FFFFFF → dbus_addr=0x1000, out_wdata=0xFFFFFF80; LD_BU on the same data → 0x00000080.
- ST_H at addr 0x2002, lsu_data=0xABCD1234 → dbus_we=1, wstrb=4'b1100, wdata=0x12341234; completion has out_rw_en=0.
- LD_W at addr 0x3001 → no dbus_req, out_ale=1, out_rw_en=0, next cycle out_valid.
- LD_HU at 0x4000 with gnt and rvalid in the same cycle, rdata=0x0000F00D → out_wdata=0x0000F00D, in_ready high the next cycle.
- rst asserted in WAIT, then rvalid → no out_valid, dbus_req=0, IDLE. With LSU_TIMEOUT_EN and TIMEOUT_CYCLES=4 and no rvalid → out_bus_err=1 after 4 WAIT cycles.

Source files
------------

// File: rtl/mem_lsu_ctrl.sv
// mem_lsu_ctrl: MEM-stage load/store unit. Issues data-bus requests for the
// EX->MEM bundle, aligns/extends load data and emits the MEM->WB bundle.
// Ports:
//   clk, rst (sync, active-high)
//   in_*     : EX->MEM bundle, in_valid/in_ready handshake
//   dbus_*   : initiator side of the data bus (req/gnt, rvalid/rdata)
//   out_*    : registered MEM->WB bundle, out_valid is a 1-cycle pulse
// Optional macro LSU_TIMEOUT_EN: response timeout after TIMEOUT_CYCLES
// WAIT cycles, reported on out_bus_err (tied 0 when the macro is undefined).
module mem_lsu_ctrl #(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       in_pc,
    input  logic [31:0]       in_inst,
    input  logic [DATA_W-1:0] in_ex_result,
    input  logic              in_rw_en,
    input  logic [4:0]        in_rw_addr,
    input  logic [DATA_W-1:0] in_lsu_data,
    input  logic [3:0]        in_lsu_op,
    output logic              dbus_req,
    output logic              dbus_we,
    output logic [ADDR_W-1:0] dbus_addr,
    output logic [3:0]        dbus_wstrb,
    output logic [DATA_W-1:0] dbus_wdata,
    input  logic              dbus_gnt,
    input  logic              dbus_rvalid,
    input  logic [DATA_W-1:0] dbus_rdata,
    output logic              out_valid,
    output logic [31:0]       out_pc,
    output logic [31:0]       out_inst,
    output logic              out_rw_en,
    output logic [4:0]        out_rw_addr,
    output logic [DATA_W-1:0] out_wdata,
    output logic              out_ale,
    output logic              out_bus_err
);

    localparam logic [3:0] OP_LD_B  = 4'd1;
    localparam logic [3:0] OP_LD_H  = 4'd2;
    localparam logic [3:0] OP_LD_W  = 4'd3;
    localparam logic [3:0] OP_LD_BU = 4'd4;
    localparam logic [3:0] OP_LD_HU = 4'd5;
    localparam logic [3:0] OP_ST_B  = 4'd6;
    localparam logic [3:0] OP_ST_H  = 4'd7;
    localparam logic [3:0] OP_ST_W  = 4'd8;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2
    } state_t;

    state_t state_q, state_d;

    // Latched access context
    logic [31:0]       pc_q, pc_d;
    logic [31:0]       inst_q, inst_d;
    logic              rw_en_q, rw_en_d;
    logic [4:0]        rw_addr_q, rw_addr_d;
    logic [3:0]        op_q, op_d;
    logic [1:0]        off_q, off_d;
    logic              ld_q, ld_d;

    // Bus request registers
    logic              req_q, req_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [3:0]        strb_q, strb_d;
    logic [DATA_W-1:0] wdat_q, wdat_d;

    // MEM->WB registers
    logic              ov_q, ov_d;
    logic [31:0]       opc_q, opc_d;
    logic [31:0]       oinst_q, oinst_d;
    logic              orwen_q, orwen_d;
    logic [4:0]        orwa_q, orwa_d;
    logic [DATA_W-1:0] owd_q, owd_d;
    logic              oale_q, oale_d;

    // Incoming op decode
    logic              is_ld, is_st, is_half, is_word, mis;
    logic [1:0]        a_off;
    logic [3:0]        st_strb;
    logic [DATA_W-1:0] st_data;

    // Load alignment
    logic [DATA_W-1:0] rsh;
    logic [DATA_W-1:0] ld_data;

    logic              rsp_done;
    logic              tmo_done;

`ifdef LSU_TIMEOUT_EN
    localparam int TW = (TIMEOUT_CYCLES > 255) ?
                        $clog2(TIMEOUT_CYCLES + 1) : 8;
    logic [TW-1:0]     cnt_q, cnt_d;
    logic              berr_q, berr_d;
`else
    logic              unused_tmo;
    assign unused_tmo = (TIMEOUT_CYCLES != 0);
`endif

    assign a_off = in_ex_result[1:0];

    always_comb begin
        is_ld   = 1'b0;
        is_st   = 1'b0;
        is_half = 1'b0;
        is_word = 1'b0;
        unique case (in_lsu_op)
            OP_LD_B, OP_LD_BU: is_ld = 1'b1;
            OP_LD_H, OP_LD_HU: begin
                is_ld   = 1'b1;
                is_half = 1'b1;
            end
            OP_LD_W: begin
                is_ld   = 1'b1;
                is_word = 1'b1;
            end
            OP_ST_B: is_st = 1'b1;
            OP_ST_H: begin
                is_st   = 1'b1;
                is_half = 1'b1;
            end
            OP_ST_W: begin
                is_st   = 1'b1;
                is_word = 1'b1;
            end
            default: ;
        endcase
    end

    assign mis = (is_half & a_off[0]) | (is_word & (|a_off));

    // Store lanes: replicate the datum so any selected lane carries it
    always_comb begin
        st_strb = 4'b0001 << a_off;
        st_data = {4{in_lsu_data[7:0]}};
        if (is_half) begin
            st_strb = 4'b0011 << a_off;
            st_data = {2{in_lsu_data[15:0]}};
        end else if (is_word) begin
            st_strb = 4'hF;
            st_data = in_lsu_data;
        end
        if (!is_st) begin
            st_strb = 4'h0;
            st_data = '0;
        end
    end

    assign rsh = dbus_rdata >> {off_q, 3'b000};

    always_comb begin
        ld_data = rsh;
        unique case (op_q)
            OP_LD_B:  ld_data = {{24{rsh[7]}}, rsh[7:0]};
            OP_LD_BU: ld_data = {24'd0, rsh[7:0]};
            OP_LD_H:  ld_data = {{16{rsh[15]}}, rsh[15:0]};
            OP_LD_HU: ld_data = {16'd0, rsh[15:0]};
            default:  ld_data = rsh;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        inst_d    = inst_q;
        rw_en_d   = rw_en_q;
        rw_addr_d = rw_addr_q;
        op_d      = op_q;
        off_d     = off_q;
        ld_d      = ld_q;
        req_d     = req_q;
        we_d      = we_q;
        addr_d    = addr_q;
        strb_d    = strb_q;
        wdat_d    = wdat_q;
        ov_d      = 1'b0;
        opc_d     = opc_q;
        oinst_d   = oinst_q;
        orwen_d   = orwen_q;
        orwa_d    = orwa_q;
        owd_d     = owd_q;
        oale_d    = oale_q;
        rsp_done  = 1'b0;
        tmo_done  = 1'b0;
`ifdef LSU_TIMEOUT_EN
        cnt_d     = cnt_q;
        berr_d    = berr_q;
`endif

        unique case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    if (!(is_ld | is_st) || mis) begin
                        // Non-memory op or misaligned access: retire now
                        ov_d    = 1'b1;
                        opc_d   = in_pc;
                        oinst_d = in_inst;
                        orwen_d = in_rw_en & ~mis;
                        orwa_d  = in_rw_addr;
                        owd_d   = in_ex_result;
                        oale_d  = mis;
`ifdef LSU_TIMEOUT_EN
                        berr_d  = 1'b0;
`endif
                    end else begin
                        pc_d      = in_pc;
                        inst_d    = in_inst;
                        rw_en_d   = in_rw_en;
                        rw_addr_d = in_rw_addr;
                        op_d      = in_lsu_op;
                        off_d     = a_off;
                        ld_d      = is_ld;
                        req_d     = 1'b1;
                        we_d      = is_st;
                        addr_d    = {in_ex_result[ADDR_W-1:2], 2'b00};
                        strb_d    = st_strb;
                        wdat_d    = st_data;
                        state_d   = S_REQ;
                    end
                end
            end
            S_REQ: begin
                if (dbus_gnt) begin
                    req_d = 1'b0;
                    if (dbus_rvalid) begin
                        rsp_done = 1'b1;
                    end else begin
                        state_d = S_WAIT;
`ifdef LSU_TIMEOUT_EN
                        cnt_d   = '0;
`endif
                    end
                end
            end
            S_WAIT: begin
                if (dbus_rvalid) begin
                    rsp_done = 1'b1;
                end else begin
`ifdef LSU_TIMEOUT_EN
                    if (cnt_q == TW'(TIMEOUT_CYCLES - 1)) begin
                        tmo_done = 1'b1;
                    end else begin
                        cnt_d = cnt_q + TW'(1);
                    end
`endif
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (rsp_done || tmo_done) begin
            state_d = S_IDLE;
            ov_d    = 1'b1;
            opc_d   = pc_q;
            oinst_d = inst_q;
            orwa_d  = rw_addr_q;
            oale_d  = 1'b0;
            orwen_d = ld_q & rw_en_q & ~tmo_done;
            owd_d   = (ld_q && !tmo_done) ? ld_data : '0;
`ifdef LSU_TIMEOUT_EN
            berr_d  = tmo_done;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            pc_q      <= '0;
            inst_q    <= '0;
            rw_en_q   <= 1'b0;
            rw_addr_q <= '0;
            op_q      <= '0;
            off_q     <= '0;
            ld_q      <= 1'b0;
            req_q     <= 1'b0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            strb_q    <= '0;
            wdat_q    <= '0;
            ov_q      <= 1'b0;
            opc_q     <= '0;
            oinst_q   <= '0;
            orwen_q   <= 1'b0;
            orwa_q    <= '0;
            owd_q     <= '0;
            oale_q    <= 1'b0;
`ifdef LSU_TIMEOUT_EN
            cnt_q     <= '0;
            berr_q    <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            inst_q    <= inst_d;
            rw_en_q   <= rw_en_d;
            rw_addr_q <= rw_addr_d;
            op_q      <= op_d;
            off_q     <= off_d;
            ld_q      <= ld_d;
            req_q     <= req_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            strb_q    <= strb_d;
            wdat_q    <= wdat_d;
            ov_q      <= ov_d;
            opc_q     <= opc_d;
            oinst_q   <= oinst_d;
            orwen_q   <= orwen_d;
            orwa_q    <= orwa_d;
            owd_q     <= owd_d;
            oale_q    <= oale_d;
`ifdef LSU_TIMEOUT_EN
            cnt_q     <= cnt_d;
            berr_q    <= berr_d;
`endif
        end
    end

    // Request and ready are masked by reset so an access is abandoned at once
    assign in_ready    = (state_q == S_IDLE) & ~rst;
    assign dbus_req    = req_q & ~rst;
    assign dbus_we     = we_q;
    assign dbus_addr   = addr_q;
    assign dbus_wstrb  = strb_q;
    assign dbus_wdata  = wdat_q;
    assign out_valid   = ov_q;
    assign out_pc      = opc_q;
    assign out_inst    = oinst_q;
    assign out_rw_en   = orwen_q;
    assign out_rw_addr = orwa_q;
    assign out_wdata   = owd_q;
    assign out_ale     = oale_q;
`ifdef LSU_TIMEOUT_EN
    assign out_bus_err = berr_q;
`else
    assign out_bus_err = 1'b0;
`endif

endmodule

// File: tb/tb_mem_lsu_ctrl.sv
// tb_mem_lsu_ctrl: self-checking bench for mem_lsu_ctrl.
// Vector table for bus accesses, scoreboard queue for the MEM->WB bundle.
module tb_mem_lsu_ctrl;

`ifdef LSU_TIMEOUT_EN
    localparam int TMO = 4;
`else
    localparam int TMO = 255;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_pc;
    logic [31:0] in_inst;
    logic [31:0] in_ex_result;
    logic        in_rw_en;
    logic [4:0]  in_rw_addr;
    logic [31:0] in_lsu_data;
    logic [3:0]  in_lsu_op;
    logic        dbus_req;
    logic        dbus_we;
    logic [31:0] dbus_addr;
    logic [3:0]  dbus_wstrb;
    logic [31:0] dbus_wdata;
    logic        dbus_gnt;
    logic        dbus_rvalid;
    logic [31:0] dbus_rdata;
    logic        out_valid;
    logic [31:0] out_pc;
    logic [31:0] out_inst;
    logic        out_rw_en;
    logic [4:0]  out_rw_addr;
    logic [31:0] out_wdata;
    logic        out_ale;
    logic        out_bus_err;

    mem_lsu_ctrl #(
        .ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_pc(in_pc), .in_inst(in_inst),
        .in_ex_result(in_ex_result),
        .in_rw_en(in_rw_en), .in_rw_addr(in_rw_addr),
        .in_lsu_data(in_lsu_data), .in_lsu_op(in_lsu_op),
        .dbus_req(dbus_req), .dbus_we(dbus_we),
        .dbus_addr(dbus_addr), .dbus_wstrb(dbus_wstrb),
        .dbus_wdata(dbus_wdata), .dbus_gnt(dbus_gnt),
        .dbus_rvalid(dbus_rvalid), .dbus_rdata(dbus_rdata),
        .out_valid(out_valid), .out_pc(out_pc),
        .out_inst(out_inst), .out_rw_en(out_rw_en),
        .out_rw_addr(out_rw_addr), .out_wdata(out_wdata),
        .out_ale(out_ale), .out_bus_err(out_bus_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] wdata;
        logic        chk_wd;
        logic        rw_en;
        logic [4:0]  rw_addr;
        logic        ale;
        logic        berr;
    } exp_t;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] addr;
        logic [31:0] sdata;
        logic [31:0] rdata;
        int          gnt_dly;
        int          rv_dly;
        bit          same;
        logic [31:0] e_addr;
        bit          e_we;
        logic [3:0]  e_strb;
        logic [31:0] e_bwd;
        logic [31:0] e_out;
    } vec_t;

    exp_t sb[$];
    vec_t vt[10];
    int   total = 0;
    int   bad   = 0;

    function automatic vec_t mk(
        input logic [3:0] op, input logic [31:0] addr,
        input logic [31:0] sdata, input logic [31:0] rdata,
        input int gd, input int rd, input bit same,
        input logic [31:0] ea, input bit ewe,
        input logic [3:0] es, input logic [31:0] ebwd,
        input logic [31:0] eo);
        vec_t v;
        v.op = op; v.addr = addr; v.sdata = sdata; v.rdata = rdata;
        v.gnt_dly = gd; v.rv_dly = rd; v.same = same;
        v.e_addr = ea; v.e_we = ewe; v.e_strb = es;
        v.e_bwd = ebwd; v.e_out = eo;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic push(input logic [31:0] pc, input logic [31:0] wd,
                        input logic cwd, input logic rwen,
                        input logic [4:0] rwa, input logic ale,
                        input logic berr);
        exp_t e;
        e.pc = pc; e.wdata = wd; e.chk_wd = cwd; e.rw_en = rwen;
        e.rw_addr = rwa; e.ale = ale; e.berr = berr;
        sb.push_back(e);
    endtask

    // Scoreboard: every out_valid pulse must match the oldest expectation
    always @(negedge clk) begin
        if (!rst && out_valid) begin
            total++;
            if (sb.size() == 0) begin
                bad++;
                $display("FAIL unexpected_out_valid: pc=%h wdata=%h",
                         out_pc, out_wdata);
            end else begin
                exp_t e;
                e = sb.pop_front();
                if (out_pc !== e.pc || out_rw_en !== e.rw_en ||
                    out_rw_addr !== e.rw_addr || out_ale !== e.ale ||
                    out_bus_err !== e.berr ||
                    (e.chk_wd && out_wdata !== e.wdata)) begin
                    bad++;
                    $display({"FAIL wb_bundle: got pc=%h wd=%h rwen=%b ",
                              "rwa=%0d ale=%b berr=%b want pc=%h wd=%h ",
                              "rwen=%b rwa=%0d ale=%b berr=%b"},
                             out_pc, out_wdata, out_rw_en, out_rw_addr,
                             out_ale, out_bus_err, e.pc, e.wdata,
                             e.rw_en, e.rw_addr, e.ale, e.berr);
                end
            end
        end
    end

    task automatic drain(input string nm);
        int n = 0;
        while (sb.size() != 0 && n < 20) begin
            @(posedge clk); #2;
            n++;
        end
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL %s_drain: pending=%0d want 0", nm, sb.size());
            sb.delete();
        end
    endtask

    task automatic drive(input logic [3:0] op, input logic [31:0] pc,
                         input logic [31:0] a, input logic [31:0] sd,
                         input logic [4:0] rd);
        in_valid     = 1'b1;
        in_pc        = pc;
        in_inst      = pc ^ 32'h0000_0013;
        in_ex_result = a;
        in_rw_en     = 1'b1;
        in_rw_addr   = rd;
        in_lsu_data  = sd;
        in_lsu_op    = op;
    endtask

    task automatic mem_access(input vec_t v, input int idx);
        logic [31:0] pc;
        bit          is_ld;
        pc    = 32'h0000_0400 + 32'(idx * 4);
        is_ld = (v.op <= 4'd5);
        drive(v.op, pc, v.addr, v.sdata, 5'(idx + 5));
        chk($sformatf("v%0d_rdy_idle", idx), {31'd0, in_ready}, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk($sformatf("v%0d_req", idx), {31'd0, dbus_req}, 1);
        chk($sformatf("v%0d_addr", idx), dbus_addr, v.e_addr);
        chk($sformatf("v%0d_we", idx), {31'd0, dbus_we}, {31'd0, v.e_we});
        chk($sformatf("v%0d_strb", idx), {28'd0, dbus_wstrb},
            {28'd0, v.e_strb});
        if (v.e_we)
            chk($sformatf("v%0d_bwdata", idx), dbus_wdata, v.e_bwd);
        chk($sformatf("v%0d_rdy_busy", idx), {31'd0, in_ready}, 0);
        for (int i = 0; i < v.gnt_dly; i++) begin
            @(posedge clk); #1;
        end
        if (v.gnt_dly > 0) begin
            chk($sformatf("v%0d_req_hold", idx), {31'd0, dbus_req}, 1);
            chk($sformatf("v%0d_addr_hold", idx), dbus_addr, v.e_addr);
        end
        push(pc, v.e_out, is_ld, is_ld, 5'(idx + 5), 1'b0, 1'b0);
        dbus_gnt = 1'b1;
        if (v.same) begin
            dbus_rvalid = 1'b1;
            dbus_rdata  = v.rdata;
        end
        @(posedge clk); #1;
        dbus_gnt    = 1'b0;
        dbus_rvalid = 1'b0;
        chk($sformatf("v%0d_req_drop", idx), {31'd0, dbus_req}, 0);
        if (!v.same) begin
            for (int i = 0; i < v.rv_dly; i++) begin
                @(posedge clk); #1;
            end
            dbus_rvalid = 1'b1;
            dbus_rdata  = v.rdata;
            @(posedge clk); #1;
            dbus_rvalid = 1'b0;
            dbus_rdata  = 32'h5555_AAAA;
        end
        chk($sformatf("v%0d_ov", idx), {31'd0, out_valid}, 1);
        chk($sformatf("v%0d_rdy_after", idx), {31'd0, in_ready}, 1);
        drain($sformatf("v%0d", idx));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vt[0] = mk(4'd1, 32'h1003, 32'h0, 32'h80FF_FFFF, 2, 0, 0,
                   32'h1000, 0, 4'h0, 32'h0, 32'hFFFF_FF80);
        vt[1] = mk(4'd4, 32'h1003, 32'h0, 32'h80FF_FFFF, 0, 1, 0,
                   32'h1000, 0, 4'h0, 32'h0, 32'h0000_0080);
        vt[2] = mk(4'd7, 32'h2002, 32'hABCD_1234, 32'h0, 1, 0, 0,
                   32'h2000, 1, 4'hC, 32'h1234_1234, 32'h0);
        vt[3] = mk(4'd5, 32'h4000, 32'h0, 32'h0000_F00D, 0, 0, 1,
                   32'h4000, 0, 4'h0, 32'h0, 32'h0000_F00D);
        vt[4] = mk(4'd2, 32'h5002, 32'h0, 32'h8001_1234, 1, 2, 0,
                   32'h5000, 0, 4'h0, 32'h0, 32'hFFFF_8001);
        vt[5] = mk(4'd3, 32'h6000, 32'h0, 32'hDEAD_BEEF, 3, 0, 0,
                   32'h6000, 0, 4'h0, 32'h0, 32'hDEAD_BEEF);
        vt[6] = mk(4'd6, 32'h7001, 32'h0000_00A5, 32'h0, 0, 0, 1,
                   32'h7000, 1, 4'h2, 32'hA5A5_A5A5, 32'h0);
        vt[7] = mk(4'd8, 32'h8004, 32'hCAFE_F00D, 32'h0, 2, 1, 0,
                   32'h8004, 1, 4'hF, 32'hCAFE_F00D, 32'h0);
        vt[8] = mk(4'd1, 32'h9001, 32'h0, 32'h0000_7F00, 0, 0, 0,
                   32'h9000, 0, 4'h0, 32'h0, 32'h0000_007F);
        vt[9] = mk(4'd5, 32'hA002, 32'h0, 32'hBEEF_0000, 1, 0, 1,
                   32'hA000, 0, 4'h0, 32'h0, 32'h0000_BEEF);

        rst = 1'b1;
        in_valid = 1'b0; in_pc = '0; in_inst = '0; in_ex_result = '0;
        in_rw_en = 1'b0; in_rw_addr = '0; in_lsu_data = '0;
        in_lsu_op = '0; dbus_gnt = 1'b0; dbus_rvalid = 1'b0;
        dbus_rdata = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", {31'd0, in_ready}, 0);
        chk("rst_out_valid", {31'd0, out_valid}, 0);
        chk("rst_dbus_req", {31'd0, dbus_req}, 0);
        chk("rst_dbus_addr", dbus_addr, 0);
        chk("rst_out_wdata", out_wdata, 0);
        chk("rst_out_flags", {29'd0, out_ale, out_bus_err, out_rw_en}, 0);
        rst = 1'b0;
        #1;
        chk("post_rst_ready", {31'd0, in_ready}, 1);
        @(posedge clk); #1;

        // Three back-to-back non-memory ops
        for (int i = 0; i < 3; i++) begin
            drive(4'd0, 32'h100 + 32'(i * 4), 32'h1234, 32'h0, 5'd3);
            chk($sformatf("nm%0d_ready", i), {31'd0, in_ready}, 1);
            push(32'h100 + 32'(i * 4), 32'h1234, 1, 1, 5'd3, 0, 0);
            @(posedge clk); #1;
            chk($sformatf("nm%0d_ov", i), {31'd0, out_valid}, 1);
        end
        // Reserved op code behaves as NONE
        drive(4'd12, 32'h200, 32'h0BAD_F00D, 32'h0, 5'd9);
        push(32'h200, 32'h0BAD_F00D, 1, 1, 5'd9, 0, 0);
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("nm_req_none", {31'd0, dbus_req}, 0);
        @(posedge clk); #1;
        chk("nm_ov_low", {31'd0, out_valid}, 0);
        drain("nm");

        // Table-driven bus accesses
        for (int i = 0; i < 10; i++) mem_access(vt[i], i);

        // Misaligned LD_W and ST_H: no bus request, ale flagged
        drive(4'd3, 32'h300, 32'h3001, 32'h0, 5'd7);
        push(32'h300, 32'h0, 0, 0, 5'd7, 1, 0);
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("mis_w_req", {31'd0, dbus_req}, 0);
        chk("mis_w_ov", {31'd0, out_valid}, 1);
        chk("mis_w_ready", {31'd0, in_ready}, 1);
        drive(4'd7, 32'h304, 32'h2001, 32'h1111_2222, 5'd8);
        push(32'h304, 32'h0, 0, 0, 5'd8, 1, 0);
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("mis_h_req", {31'd0, dbus_req}, 0);
        drain("mis");

        // rvalid while idle is ignored
        dbus_rvalid = 1'b1;
        dbus_rdata  = 32'hFFFF_FFFF;
        @(posedge clk); #1;
        dbus_rvalid = 1'b0;
        chk("idle_rvalid_ov", {31'd0, out_valid}, 0);

        // Reset while waiting for a response, then a stale rvalid
        drive(4'd3, 32'h500, 32'hB000, 32'h0, 5'd10);
        @(posedge clk); #1;
        in_valid = 1'b0;
        dbus_gnt = 1'b1;
        @(posedge clk); #1;
        dbus_gnt = 1'b0;
        chk("rw_in_wait", {31'd0, in_ready}, 0);
        rst = 1'b1;
        #1;
        chk("rw_req_low", {31'd0, dbus_req}, 0);
        chk("rw_rdy_rst", {31'd0, in_ready}, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        dbus_rvalid = 1'b1;
        dbus_rdata  = 32'h1234_5678;
        @(posedge clk); #1;
        dbus_rvalid = 1'b0;
        chk("rw_ov_none", {31'd0, out_valid}, 0);
        chk("rw_req_none", {31'd0, dbus_req}, 0);
        chk("rw_ready", {31'd0, in_ready}, 1);
        chk("rw_wdata_clr", out_wdata, 0);
        @(posedge clk); #1;
        chk("rw_ov_none2", {31'd0, out_valid}, 0);

`ifdef LSU_TIMEOUT_EN
        begin
            int n = 0;
            drive(4'd3, 32'h600, 32'hC000, 32'h0, 5'd11);
            @(posedge clk); #1;
            in_valid = 1'b0;
            dbus_gnt = 1'b1;
            push(32'h600, 32'h0, 0, 0, 5'd11, 0, 1);
            @(posedge clk); #1;
            dbus_gnt = 1'b0;
            while (!out_valid && n < 20) begin
                @(posedge clk); #1;
                n++;
            end
            chk("tmo_cycles", 32'(n), 32'(TMO));
            chk("tmo_berr", {31'd0, out_bus_err}, 1);
            drain("tmo");
        end
`endif

        drain("final");
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
